// File: rtl/display_color_encoder_pipe_if.sv
// Pixel stream bundle for the colour encoder: input word, per-word settings and output word with valid/ready.
interface display_color_encoder_pipe_if #(
  parameter int segments     = 2,
  parameter int channel_bits = 8
);
  localparam int W = segments * 3 * channel_bits;

  logic [W-1:0]            in_pixel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    gamma_en;
  logic [channel_bits-1:0] brightness;
  logic [W-1:0]            out_pixel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_pixel, in_valid, gamma_en, brightness, out_ready,
    input  in_ready, out_pixel, out_valid
  );

  modport slave (
    input  in_pixel, in_valid, gamma_en, brightness, out_ready,
    output in_ready, out_pixel, out_valid
  );
endinterface

// File: rtl/display_color_encoder_pipe.sv
// Per-channel optional gamma-2 then brightness scale; 3-cycle latency, one word/cycle.
// Backpressure: in_ready is combinational from out_ready through the stage valids, so bubbles collapse and nothing is dropped.
module display_color_encoder_pipe #(
  parameter int segments     = 2,
  parameter int channel_bits = 8
) (
  input logic                         clk,
  input logic                         rst,
  display_color_encoder_pipe_if.slave bus
);
  localparam int CB  = channel_bits;
  localparam int NCH = segments * 3;
  localparam int W   = NCH * CB;
  localparam int PW  = 2 * CB + 1;

  // (a*(b+1))>>CB never exceeds all-ones, so gamma (b=a) and brightness share it.
  function automatic logic [CB-1:0] scale(input logic [CB-1:0] a, input logic [CB-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * (PW'(b) + PW'(1));
    return CB'(p >> CB);
  endfunction

  function automatic logic [W-1:0] gamma_word(input logic [W-1:0] w, input logic en);
    logic [W-1:0] r;
    r = w;
    if (en) begin
      for (int i = 0; i < NCH; i++) r[i*CB +: CB] = scale(w[i*CB +: CB], w[i*CB +: CB]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bright_word(input logic [W-1:0] w, input logic [CB-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*CB +: CB] = scale(w[i*CB +: CB], b);
    return r;
  endfunction

  logic [W-1:0]  s1_pix_q, s1_pix_d;
  logic          s1_gam_q, s1_gam_d;
  logic [CB-1:0] s1_bri_q, s1_bri_d;
  logic          s1_vld_q, s1_vld_d;
  logic [W-1:0]  s2_pix_q, s2_pix_d;
  logic [CB-1:0] s2_bri_q, s2_bri_d;
  logic          s2_vld_q, s2_vld_d;
  logic [W-1:0]  s3_pix_q, s3_pix_d;
  logic          s3_vld_q, s3_vld_d;
  logic          rdy1, rdy2, rdy3;

  always_comb begin
    rdy3 = !s3_vld_q || bus.out_ready;
    rdy2 = !s2_vld_q || rdy3;
    rdy1 = !s1_vld_q || rdy2;

    s1_pix_d = s1_pix_q;
    s1_gam_d = s1_gam_q;
    s1_bri_d = s1_bri_q;
    s1_vld_d = s1_vld_q;
    s2_pix_d = s2_pix_q;
    s2_bri_d = s2_bri_q;
    s2_vld_d = s2_vld_q;
    s3_pix_d = s3_pix_q;
    s3_vld_d = s3_vld_q;

    // Settings travel with the word so later changes never touch words in flight.
    if (rdy1) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_pix_d = bus.in_pixel;
        s1_gam_d = bus.gamma_en;
        s1_bri_d = bus.brightness;
      end
    end

    if (rdy2) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_pix_d = gamma_word(s1_pix_q, s1_gam_q);
        s2_bri_d = s1_bri_q;
      end
    end

    if (rdy3) begin
      s3_vld_d = s2_vld_q;
      if (s2_vld_q) s3_pix_d = bright_word(s2_pix_q, s2_bri_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_pix_q <= '0;
      s1_gam_q <= 1'b0;
      s1_bri_q <= '0;
      s1_vld_q <= 1'b0;
      s2_pix_q <= '0;
      s2_bri_q <= '0;
      s2_vld_q <= 1'b0;
      s3_pix_q <= '0;
      s3_vld_q <= 1'b0;
    end else begin
      s1_pix_q <= s1_pix_d;
      s1_gam_q <= s1_gam_d;
      s1_bri_q <= s1_bri_d;
      s1_vld_q <= s1_vld_d;
      s2_pix_q <= s2_pix_d;
      s2_bri_q <= s2_bri_d;
      s2_vld_q <= s2_vld_d;
      s3_pix_q <= s3_pix_d;
      s3_vld_q <= s3_vld_d;
    end
  end

  assign bus.in_ready  = rdy1;
  assign bus.out_pixel = s3_pix_q;
  assign bus.out_valid = s3_vld_q;
endmodule

// File: tb/tb_display_color_encoder_pipe.sv
// Randomised and directed bench for display_color_encoder_pipe against a per-channel arithmetic model.
module tb_display_color_encoder_pipe;
  localparam int SEG = 2;
  localparam int CB  = 8;
  localparam int NCH = SEG * 3;
  localparam int W   = NCH * CB;

  typedef struct {
    logic [W-1:0]  pix;
    bit            gam;
    logic [CB-1:0] bri;
  } snd_t;

  typedef struct {
    logic [W-1:0] pix;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  display_color_encoder_pipe_if #(.segments(SEG), .channel_bits(CB)) bus ();

  display_color_encoder_pipe #(.segments(SEG), .channel_bits(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  snd_t         send_q[$];
  exp_t         exp_q[$];
  logic [W-1:0] out_log[$];
  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int emit_cnt = 0;
  bit chk_lat  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Model: gamma is c*(c+1)/2^CB, brightness is g*(b+1)/2^CB, per channel.
  function automatic logic [W-1:0] ref_enc(input logic [W-1:0] p, input bit g, input logic [CB-1:0] b);
    logic [W-1:0] r;
    int c;
    int full;
    full = 1 << CB;
    for (int i = 0; i < NCH; i++) begin
      c = int'(p[i*CB +: CB]);
      if (g) c = c * (c + 1) / full;
      c = c * (int'(b) + 1) / full;
      r[i*CB +: CB] = c[CB-1:0];
    end
    return r;
  endfunction

  task automatic push(input logic [W-1:0] pix, input bit gam, input logic [CB-1:0] bri);
    snd_t s;
    s.pix = pix;
    s.gam = gam;
    s.bri = bri;
    send_q.push_back(s);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(tag, 64'(send_q.size() + exp_q.size()), 64'(0));
  endtask

  // Driver: presents the head of send_q just after each rising edge.
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_pixel   = '0;
    bus.gamma_en   = 1'b0;
    bus.brightness = '0;
    forever begin
      @(posedge clk);
      #1;
      if (send_q.size() > 0) begin
        bus.in_valid   = 1'b1;
        bus.in_pixel   = send_q[0].pix;
        bus.gamma_en   = send_q[0].gam;
        bus.brightness = send_q[0].bri;
      end else begin
        bus.in_valid   = 1'b0;
        bus.in_pixel   = W'({$urandom, $urandom});
        bus.gamma_en   = 1'($urandom);
        bus.brightness = CB'($urandom);
      end
    end
  end

  // Monitor: handshakes seen at the falling edge complete on the next rising edge.
  initial begin
    exp_t e;
    snd_t s;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() == 0) check("idle_vld", 64'(bus.out_valid), 64'(0));
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pixel", 64'(bus.out_pixel), 64'(e.pix));
          if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(3));
          out_log.push_back(bus.out_pixel);
          emit_cnt++;
        end
        if (bus.in_valid && bus.in_ready && send_q.size() > 0) begin
          s = send_q.pop_front();
          e.pix = ref_enc(s.pix, s.gam, s.bri);
          e.cyc = cyc;
          exp_q.push_back(e);
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin
    logic [W-1:0] words[5];
    int li;
    int base;
    int n;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_vld", 64'(bus.out_valid), 64'(0));
    check("rst_out_pix", 64'(bus.out_pixel), 64'(0));
    check("rst_in_rdy", 64'(bus.in_ready), 64'(1));

    // Linear unity-gain stream, checked for latency and order.
    words[0] = 48'h000000_ffffff;
    words[1] = 48'h000000_ffff00;
    words[2] = 48'h000000_ff00ff;
    words[3] = 48'h000000_00ffff;
    words[4] = 48'hffffff_000000;
    @(posedge clk);
    #2;
    chk_lat = 1'b1;
    li = out_log.size();
    for (int i = 0; i < 5; i++) push(words[i], 1'b0, 8'hff);
    wait_drain("drain_linear");
    chk_lat = 1'b0;
    for (int i = 0; i < 5; i++) check("linear_word", 64'(out_log[li+i]), 64'(words[i]));

    li = out_log.size();
    push(48'h808080_ff0000, 1'b1, 8'hff);
    push(48'hffffff_ffffff, 1'b0, 8'h7f);
    push(48'hffffff_ffffff, 1'b0, 8'h00);
    push(48'hffffff_ffffff, 1'b0, 8'hff);
    push(48'hffffff_ffffff, 1'b0, 8'h00);
    wait_drain("drain_directed");
    check("gamma_word", 64'(out_log[li]), 64'(48'h404040_ff0000));
    check("bri_7f", 64'(out_log[li+1]), 64'(48'h7f7f7f_7f7f7f));
    check("bri_00", 64'(out_log[li+2]), 64'(48'h000000_000000));
    check("bri_frozen_a", 64'(out_log[li+3]), 64'(48'hffffff_ffffff));
    check("bri_frozen_b", 64'(out_log[li+4]), 64'(48'h000000_000000));

    // Stall with five words offered: three fit, then the pipe holds.
    @(posedge clk);
    #2;
    bus.out_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) push(W'({$urandom, $urandom}), 1'($urandom), CB'($urandom));
    repeat (8) @(negedge clk);
    check("stall_acc", 64'(acc_cnt - base), 64'(3));
    check("stall_in_rdy", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_vld", 64'(bus.out_valid), 64'(1));
      check("stall_hold", 64'(bus.out_pixel), 64'(exp_q[0].pix));
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_vld", 64'(bus.out_valid), 64'(1));
    end
    wait_drain("drain_stall");

    // Random words, settings and consumer backpressure.
    for (int i = 0; i < 60; i++) begin
      logic [CB-1:0] b;
      b = CB'($urandom);
      if (i % 7 == 0) b = '1;
      if (i % 11 == 0) b = '0;
      push(W'({$urandom, $urandom}), 1'($urandom), b);
    end
    repeat (250) begin
      @(posedge clk);
      #2;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.out_ready = 1'b1;
    wait_drain("drain_random");

    // Reset with two words in flight: neither may ever appear.
    base = acc_cnt;
    push(48'h123456_789abc, 1'b0, 8'hff);
    push(48'hfedcba_987654, 1'b1, 8'hff);
    n = 0;
    while (acc_cnt < base + 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rst_mid_acc", 64'(acc_cnt - base), 64'(2));
    rst = 1'b1;
    li  = emit_cnt;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_vld", 64'(bus.out_valid), 64'(0));
    check("rst_mid_pix", 64'(bus.out_pixel), 64'(0));
    repeat (10) @(negedge clk);
    check("rst_mid_none", 64'(emit_cnt - li), 64'(0));
    check("rst_mid_rdy", 64'(bus.in_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
